pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'h8000_0180: exception handler address.
REQ-003 Parameter DRAIN_CYC, default 2, legal range 1..7: fetch-suppressed cycles after an exception.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 stall  in  1  hazard-unit hold; freezes sequential advance.
REQ-007 br_taken  in  1  resolved taken branch this cycle.
REQ-008 br_target  in  32  branch target.
REQ-009 jmp  in  1  jump this cycle.
REQ-010 jmp_target  in  32  jump target.
REQ-011 exc_req  in  1  exception request from the pipeline.
REQ-012 exc_pc  in  32  PC of the faulting instruction.
REQ-013 eret  in  1  return from exception.
REQ-014 pc  out  32  current fetch address.
REQ-015 pc_valid  out  1  fetch at pc is architecturally valid.
REQ-016 flush_if  out  1  squash the IF/ID register.
REQ-017 flush_id  out  1  squash the ID/EX register.
REQ-018 epc  out  32  saved exception return address.
REQ-019 addr_err  out  1  one-cycle pulse on a misaligned redirect.

Function
REQ-020 FSM states: BOOT, RUN, DRAIN.
REQ-021 BOOT: pc=RESET_VEC, pc_valid=0; after one clock it moves to RUN with pc unchanged.
REQ-022 In RUN, events are evaluated once per edge with priority exc_req > eret > br_taken > jmp > sequential.
REQ-023 Sequential advance: pc <= pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0) when stall=0; pc holds when stall=1.
REQ-024 Redirects (exc_req, eret, br_taken, jmp) override stall.
REQ-025 br_taken or jmp: pc <= target at the next edge, and flush_if=1 for exactly the following cycle.
REQ-026 Misaligned target (bits[1:0]!=0): treated as an exception with epc <= target, and addr_err=1 for one cycle.
REQ-027 exc_req: epc <= exc_pc, pc <= EXC_VEC, state <= DRAIN, counter <= DRAIN_CYC.
REQ-028 In DRAIN: flush_if=1, flush_id=1, pc_valid=0, pc holds EXC_VEC.
REQ-029 In DRAIN, exc_req, eret, br_taken, jmp and stall are ignored; the counter decrements each cycle and the FSM enters RUN when it reaches 0.
REQ-030 eret in RUN: pc <= epc, flush_if=1 for one cycle; epc unchanged.
REQ-031 pc_valid=1 in RUN only.
REQ-032 All outputs are registered; no input-to-output combinational path.
REQ-033 Latency: an event sampled at edge N produces its pc/flush outputs after edge N.

Reset
REQ-034 While reset=0, asynchronously: state=BOOT, pc=RESET_VEC, epc=0, pc_valid=0, flush_if=0, flush_id=0, addr_err=0, counter=0.
REQ-035 Reset asserted mid-DRAIN or mid-redirect aborts the operation immediately; no pending flush survives reset.
REQ-036 Reset deassertion takes effect at the first subsequent rising edge; BOOT lasts one cycle from that edge.

Structure
REQ-037 State encoding and the default RESET_VEC/EXC_VEC constants live in the shared package pipe_pkg.
REQ-038 The sub-module pc_redirect_mux is the combinational priority and alignment selector; the FSM, pc, epc and counter registers sit in pc_sequencer.
REQ-039 The existing PC register is bypassed: pc_sequencer owns the PC.

Verification
REQ-040 Reset release with stall=0 -> pc_valid=0 for one cycle, then pc 0x0, 0x4, 0x8 with pc_valid=1.
REQ-041 stall=1 for 3 cycles at pc=0x10 -> pc stays 0x10 for 3 cycles, then advances to 0x14.
REQ-042 br_taken=1 and jmp=1 in the same cycle with stall=1, br_target=0x40, jmp_target=0x80 -> pc=0x40, flush_if=1 for one cycle.
REQ-043 exc_req with exc_pc=0x24 and DRAIN_CYC=2 -> epc=0x24, pc=0x8000_0180, flush_if=flush_id=1 and pc_valid=0 for 2 cycles, then pc 0x8000_0184.
REQ-044 jmp with jmp_target=0x42 -> addr_err pulse, epc=0x42, pc=0x8000_0180, DRAIN entered.
REQ-045 eret after the REQ-043 exception -> pc=0x24, flush_if one cycle; reset asserted mid-DRAIN -> outputs immediately at their REQ-034 values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the PC sequencer and its redirect mux.
//   - FSM state encodings (BOOT / RUN / DRAIN)
//   - default reset and exception vectors
//   - redirect-source selector type
//   - alignment helper for fetch targets
package pipe_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

    // Drain counter is wide enough for the largest legal drain length (7).
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_EXC,
        SEL_ERET,
        SEL_BR,
        SEL_JMP
    } sel_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational priority/alignment selector for the next fetch address.
// Priority: exc_req > eret > br_taken > jmp > stall-hold > pc+4.
// A misaligned branch/jump target is converted into an exception whose
// saved return address is the offending target.
// Ports:
//   i_pc, i_epc          current pc and saved exception pc
//   i_stall              hold request (overridden by any redirect)
//   i_br_taken/_target   resolved taken branch
//   i_jmp/_target        jump
//   i_exc_req/_pc        exception request and faulting pc
//   i_eret               return from exception
//   o_next_pc            next pc when no exception is taken
//   o_take_exc           an exception (real or alignment) wins this cycle
//   o_exc_epc            value to save into epc when o_take_exc
//   o_addr_err           the winning branch/jump target was misaligned
//   o_flush_if           aligned redirect that squashes IF/ID next cycle
module pc_redirect_mux
    import pipe_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_epc,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jmp,
    input  logic [31:0] i_jmp_target,
    input  logic        i_exc_req,
    input  logic [31:0] i_exc_pc,
    input  logic        i_eret,
    output logic [31:0] o_next_pc,
    output logic        o_take_exc,
    output logic [31:0] o_exc_epc,
    output logic        o_addr_err,
    output logic        o_flush_if
);

    sel_t        w_sel;
    logic [31:0] w_target;
    logic        w_is_ctl;
    logic        w_misalign;

    always_comb begin
        w_sel = SEL_SEQ;
        if (i_exc_req)       w_sel = SEL_EXC;
        else if (i_eret)     w_sel = SEL_ERET;
        else if (i_br_taken) w_sel = SEL_BR;
        else if (i_jmp)      w_sel = SEL_JMP;
        else if (i_stall)    w_sel = SEL_HOLD;
    end

    // Only meaningful when w_sel is BR or JMP; branch wins over jump.
    assign w_target   = i_br_taken ? i_br_target : i_jmp_target;
    assign w_is_ctl   = (w_sel == SEL_BR) || (w_sel == SEL_JMP);
    assign w_misalign = w_is_ctl && is_misaligned(w_target);

    assign o_take_exc = (w_sel == SEL_EXC) || w_misalign;
    assign o_exc_epc  = (w_sel == SEL_EXC) ? i_exc_pc : w_target;
    assign o_addr_err = w_misalign;
    assign o_flush_if = (w_sel == SEL_ERET) || (w_is_ctl && !w_misalign);

    always_comb begin
        o_next_pc = i_pc + 32'd4;  // wraps modulo 2^32
        case (w_sel)
            SEL_EXC:  o_next_pc = EXC_VEC;
            SEL_ERET: o_next_pc = i_epc;
            SEL_BR:   o_next_pc = w_misalign ? EXC_VEC : w_target;
            SEL_JMP:  o_next_pc = w_misalign ? EXC_VEC : w_target;
            SEL_HOLD: o_next_pc = i_pc;
            default:  o_next_pc = i_pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC: boot sequencing, sequential advance, branch/jump/eret
// redirects, exception entry with a fetch-suppressed drain window.
// All outputs are registered; events sampled at edge N show after edge N.
// Ports:
//   clk, reset (async, active-low)
//   stall, br_taken/br_target, jmp/jmp_target, exc_req/exc_pc, eret
//   pc, pc_valid        current fetch address and its validity (RUN only)
//   flush_if, flush_id  squash IF/ID and ID/EX registers
//   epc                 saved exception return address
//   addr_err            one-cycle pulse on a misaligned branch/jump target
//   dbg_state           FSM state (pipe_pkg ST_* encoding) for observation
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic        addr_err,
    output logic [1:0]  dbg_state
);

    localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN_CYC);

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_epc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pc_valid;
    logic             r_flush_if;
    logic             r_flush_id;
    logic             r_addr_err;

    logic [1:0]       w_state_n;
    logic [31:0]      w_pc_n;
    logic [31:0]      w_epc_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_pc_valid_n;
    logic             w_flush_if_n;
    logic             w_flush_id_n;
    logic             w_addr_err_n;

    logic [31:0]      w_next_pc;
    logic             w_take_exc;
    logic [31:0]      w_exc_epc;
    logic             w_addr_err;
    logic             w_redirect;

    pc_redirect_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_mux (
        .i_pc         (r_pc),
        .i_epc        (r_epc),
        .i_stall      (stall),
        .i_br_taken   (br_taken),
        .i_br_target  (br_target),
        .i_jmp        (jmp),
        .i_jmp_target (jmp_target),
        .i_exc_req    (exc_req),
        .i_exc_pc     (exc_pc),
        .i_eret       (eret),
        .o_next_pc    (w_next_pc),
        .o_take_exc   (w_take_exc),
        .o_exc_epc    (w_exc_epc),
        .o_addr_err   (w_addr_err),
        .o_flush_if   (w_redirect)
    );

    // Output flags are computed for the cycle after the edge, so each one
    // describes the state being entered rather than the state being left.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_epc_n      = r_epc;
        w_cnt_n      = r_cnt;
        w_pc_valid_n = 1'b0;
        w_flush_if_n = 1'b0;
        w_flush_id_n = 1'b0;
        w_addr_err_n = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_n    = ST_RUN;
                w_pc_valid_n = 1'b1;
            end
            ST_RUN: begin
                if (w_take_exc) begin
                    w_state_n    = ST_DRAIN;
                    w_pc_n       = EXC_VEC;
                    w_epc_n      = w_exc_epc;
                    w_cnt_n      = DRAIN_CNT;
                    w_flush_if_n = 1'b1;
                    w_flush_id_n = 1'b1;
                    w_addr_err_n = w_addr_err;
                end else begin
                    w_pc_n       = w_next_pc;
                    w_pc_valid_n = 1'b1;
                    w_flush_if_n = w_redirect;
                end
            end
            ST_DRAIN: begin
                // Pipeline inputs are ignored here; only the counter moves.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_n    = ST_RUN;
                    w_cnt_n      = '0;
                    w_pc_valid_n = 1'b1;
                end else begin
                    w_cnt_n      = r_cnt - CNT_W'(1);
                    w_flush_if_n = 1'b1;
                    w_flush_id_n = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_BOOT;
                w_pc_n    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_cnt      <= '0;
            r_pc_valid <= 1'b0;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_epc      <= w_epc_n;
            r_cnt      <= w_cnt_n;
            r_pc_valid <= w_pc_valid_n;
            r_flush_if <= w_flush_if_n;
            r_flush_id <= w_flush_id_n;
            r_addr_err <= w_addr_err_n;
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign flush_if  = r_flush_if;
    assign flush_id  = r_flush_id;
    assign epc       = r_epc;
    assign addr_err  = r_addr_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        eret;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] epc;
  logic        addr_err;
  logic [1:0]  dbg_state;

  localparam logic [31:0] EXC_V = 32'h8000_0180;
  localparam logic [1:0]  S_BOOT  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pc_sequencer #(
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (EXC_V),
    .DRAIN_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc_req    (exc_req),
    .exc_pc     (exc_pc),
    .eret       (eret),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush_if   (flush_if),
    .flush_id   (flush_id),
    .epc        (epc),
    .addr_err   (addr_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] xpc;
    logic        eret;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_fif;
    logic        e_fid;
    logic [31:0] e_epc;
    logic        e_aerr;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic add_v(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic x, input logic [31:0] xp, input logic er,
                       input logic [31:0] ep, input logic ev, input logic ef,
                       input logic ed, input logic [31:0] ee, input logic ea,
                       input logic [1:0] es);
    vec_t v;
    v.stall = s; v.br = b; v.brt = bt; v.jmp = j; v.jt = jt;
    v.exc = x; v.xpc = xp; v.eret = er;
    v.e_pc = ep; v.e_valid = ev; v.e_fif = ef; v.e_fid = ed;
    v.e_epc = ee; v.e_aerr = ea; v.e_st = es;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
    exc_req = 0; exc_pc = 0; eret = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    stall = v.stall; br_taken = v.br; br_target = v.brt;
    jmp = v.jmp; jmp_target = v.jt;
    exc_req = v.exc; exc_pc = v.xpc; eret = v.eret;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                         input logic e_fif, input logic e_fid, input logic [31:0] e_epc,
                         input logic e_aerr, input logic [1:0] e_st);
    chk({tag, " pc"},       pc,              e_pc);
    chk({tag, " pc_valid"}, 32'(pc_valid),   32'(e_valid));
    chk({tag, " flush_if"}, 32'(flush_if),   32'(e_fif));
    chk({tag, " flush_id"}, 32'(flush_id),   32'(e_fid));
    chk({tag, " epc"},      epc,             e_epc);
    chk({tag, " addr_err"}, 32'(addr_err),   32'(e_aerr));
    chk({tag, " state"},    32'(dbg_state),  32'(e_st));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive_idle();

    // Columns: stall br brt jmp jt exc xpc eret | pc valid fif fid epc aerr state
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0000,1,0,0,32'h0,0,S_RUN);    // BOOT -> RUN
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0004,1,0,0,32'h0,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0008,1,0,0,32'h0,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_000C,1,0,0,32'h0,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0010,1,0,0,32'h0,0,S_RUN);
    add_v(1,0,0,0,0,0,0,0, 32'h0000_0010,1,0,0,32'h0,0,S_RUN);    // stall x3
    add_v(1,0,0,0,0,0,0,0, 32'h0000_0010,1,0,0,32'h0,0,S_RUN);
    add_v(1,0,0,0,0,0,0,0, 32'h0000_0010,1,0,0,32'h0,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0014,1,0,0,32'h0,0,S_RUN);
    add_v(1,1,32'h40,1,32'h80,0,0,0, 32'h0000_0040,1,1,0,32'h0,0,S_RUN); // br beats jmp, beats stall
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0044,1,0,0,32'h0,0,S_RUN);
    add_v(0,0,0,1,32'h100,0,0,0, 32'h0000_0100,1,1,0,32'h0,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0104,1,0,0,32'h0,0,S_RUN);
    add_v(0,1,32'h200,0,0,1,32'h24,0, EXC_V,0,1,1,32'h24,0,S_DRAIN); // exc beats br
    add_v(1,1,32'h300,0,0,0,0,1, EXC_V,0,1,1,32'h24,0,S_DRAIN);      // ignored in DRAIN
    add_v(0,0,0,0,0,1,32'h99,0, EXC_V,1,0,0,32'h24,0,S_RUN);         // ignored, back to RUN
    add_v(0,0,0,0,0,0,0,0, 32'h8000_0184,1,0,0,32'h24,0,S_RUN);
    add_v(0,1,32'h500,0,0,0,0,1, 32'h0000_0024,1,1,0,32'h24,0,S_RUN); // eret beats br
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0028,1,0,0,32'h24,0,S_RUN);
    add_v(1,0,0,0,0,0,0,1, 32'h0000_0024,1,1,0,32'h24,0,S_RUN);       // eret beats stall
    add_v(0,0,0,1,32'h42,0,0,0, EXC_V,0,1,1,32'h42,1,S_DRAIN);        // misaligned jmp
    add_v(0,0,0,0,0,0,0,0, EXC_V,0,1,1,32'h42,0,S_DRAIN);
    add_v(0,0,0,0,0,0,0,0, EXC_V,1,0,0,32'h42,0,S_RUN);
    add_v(0,1,32'h201,1,32'h80,0,0,0, EXC_V,0,1,1,32'h201,1,S_DRAIN); // misaligned br wins
    add_v(0,0,0,0,0,0,0,0, EXC_V,0,1,1,32'h201,0,S_DRAIN);
    add_v(0,0,0,0,0,0,0,0, EXC_V,1,0,0,32'h201,0,S_RUN);
    add_v(0,1,32'hFFFF_FFFC,0,0,0,0,0, 32'hFFFF_FFFC,1,1,0,32'h201,0,S_RUN);
    add_v(0,0,0,0,0,0,0,0, 32'h0000_0000,1,0,0,32'h201,0,S_RUN);      // wrap
    add_v(1,0,0,0,0,1,32'h8,0, EXC_V,0,1,1,32'h8,0,S_DRAIN);          // exc beats stall
    add_v(0,0,0,0,0,0,0,0, EXC_V,0,1,1,32'h8,0,S_DRAIN);
    add_v(0,0,0,0,0,0,0,0, EXC_V,1,0,0,32'h8,0,S_RUN);
    add_v(0,0,0,0,0,0,0,1, 32'h0000_0008,1,1,0,32'h8,0,S_RUN);

    // Asynchronous reset before any clock edge.
    #3;
    chk_all("reset", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("boot", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_fif,
              vecs[i].e_fid, vecs[i].e_epc, vecs[i].e_aerr, vecs[i].e_st);
    end

    // Reset asserted in the middle of DRAIN: everything returns at once.
    drive_idle();
    exc_req = 1; exc_pc = 32'h30;
    step();
    drive_idle();
    chk_all("pre_rst_drain", EXC_V, 0, 1, 1, 32'h30, 0, S_DRAIN);
    #2 reset = 1'b0;
    #1;
    chk_all("rst_mid_drain", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("reboot", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);
    @(negedge clk);
    chk_all("reboot_run", 32'h0, 1, 0, 0, 32'h0, 0, S_RUN);
    step();
    chk_all("reboot_seq", 32'h4, 1, 0, 0, 32'h0, 0, S_RUN);

    // Reset asserted during an addr_err pulse / pending flush.
    jmp = 1; jmp_target = 32'h43;
    step();
    drive_idle();
    chk_all("pre_rst_aerr", EXC_V, 0, 1, 1, 32'h43, 1, S_DRAIN);
    #2 reset = 1'b0;
    #1;
    chk_all("rst_mid_aerr", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);
    @(negedge clk);
    reset = 1'b1;
    step();
    jmp = 1; jmp_target = 32'h60;
    step();
    drive_idle();
    chk_all("pre_rst_jmp", 32'h60, 1, 1, 0, 32'h0, 0, S_RUN);
    #2 reset = 1'b0;
    #1;
    chk_all("rst_mid_jmp", 32'h0, 0, 0, 0, 32'h0, 0, S_BOOT);
    @(negedge clk);
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
